// File: rtl/dac_bank_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dac_bank_serializer
// Purpose  : 32 x 16-bit DAC setpoint register file plus a serial loader that
//            streams every setpoint into a bank of quad-channel DAC chips.
// Revision : 1.0  initial release
// ============================================================================
module dac_bank_serializer #(
    parameter int         NUM_CHIPS   = 8,
    parameter int         CH_PER_CHIP = 4,
    parameter logic [3:0] DAC_CMD     = 4'b0011
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dac_we_i,
    input  logic [4:0]           dac_waddr_i,
    input  logic [15:0]          dac_dat_i,
    input  logic [4:0]           dac_raddr_i,
    output logic [15:0]          dac_dat_o,
    input  logic                 update_i,
    output logic                 busy_o,
    output logic                 SCLK,
    output logic                 NSYNC,
    output logic [NUM_CHIPS-1:0] DIN
);

    localparam int         c_NUM_REGS   = NUM_CHIPS * CH_PER_CHIP;
    localparam logic [5:0] c_SHIFT_LAST = 6'd47;
    localparam logic [5:0] c_GAP_LAST   = 6'd1;
    localparam logic [1:0] c_CH_LAST    = 2'(CH_PER_CHIP - 1);

    generate
        if (c_NUM_REGS != 32) begin : g_param_check
            $error("NUM_CHIPS*CH_PER_CHIP must equal 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [15:0]                  regs_q [c_NUM_REGS];
    logic [15:0]                  regs_d [c_NUM_REGS];
    logic [15:0]                  dat_q, dat_d;
    logic [1:0]                   ch_q, ch_d;
    logic [5:0]                   cnt_q, cnt_d;
    logic [NUM_CHIPS-1:0][23:0]   sr_q, sr_d;
    logic                         busy_q, busy_d;
    logic                         sclk_q, sclk_d;
    logic                         nsync_q, nsync_d;
    logic [NUM_CHIPS-1:0]         din_q, din_d;
    logic [NUM_CHIPS-1:0][23:0]   w_frame;

    // Read samples the pre-write contents, so same-address read/write returns old data
    always_comb begin
        regs_d = regs_q;
        if (dac_we_i) begin
            regs_d[dac_waddr_i] = dac_dat_i;
        end
        dat_d = regs_q[dac_raddr_i];
    end

    always_comb begin
        for (int k = 0; k < NUM_CHIPS; k++) begin
            w_frame[k] = {DAC_CMD, 2'b00, ch_q, regs_q[5'(CH_PER_CHIP * k) + 5'(ch_q)]};
        end
    end

    // Outputs are computed for the cycle being entered, so every pin is a flop
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        busy_d  = busy_q;
        sclk_d  = sclk_q;
        nsync_d = nsync_q;
        din_d   = din_q;
        case (state_q)
            S_IDLE: begin
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                nsync_d = 1'b1;
                din_d   = '0;
                if (update_i) begin
                    state_d = S_LOAD;
                    ch_d    = 2'd0;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                cnt_d   = 6'd0;
                sclk_d  = 1'b1;
                nsync_d = 1'b0;
                for (int k = 0; k < NUM_CHIPS; k++) begin
                    din_d[k] = w_frame[k][23];
                    sr_d[k]  = {w_frame[k][22:0], 1'b0};
                end
            end
            S_SHIFT: begin
                nsync_d = 1'b0;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == c_SHIFT_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = 6'd0;
                    nsync_d = 1'b1;
                    sclk_d  = 1'b0;
                    din_d   = '0;
                end else if (!cnt_q[0]) begin
                    sclk_d = 1'b0;
                end else begin
                    sclk_d = 1'b1;
                    for (int k = 0; k < NUM_CHIPS; k++) begin
                        din_d[k] = sr_q[k][23];
                        sr_d[k]  = {sr_q[k][22:0], 1'b0};
                    end
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == c_GAP_LAST) begin
                    cnt_d = 6'd0;
                    if (ch_q == c_CH_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_LOAD;
                        ch_d    = ch_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                regs_q[i] <= 16'd0;
            end
            state_q <= S_IDLE;
            dat_q   <= 16'd0;
            ch_q    <= 2'd0;
            cnt_q   <= 6'd0;
            sr_q    <= '0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            nsync_q <= 1'b1;
            din_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            dat_q   <= dat_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            nsync_q <= nsync_d;
            din_q   <= din_d;
        end
    end

    assign dac_dat_o = dat_q;
    assign busy_o    = busy_q;
    assign SCLK      = sclk_q;
    assign NSYNC     = nsync_q;
    assign DIN       = din_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_bank_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_bank_serializer
// Purpose  : Self-checking bench: register file vectors, frame decode of the
//            serial bus against a setpoint model, and corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_dac_bank_serializer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dac_we_i;
    logic [4:0]  dac_waddr_i;
    logic [15:0] dac_dat_i;
    logic [4:0]  dac_raddr_i;
    logic [15:0] dac_dat_o;
    logic        update_i;
    logic        busy_o;
    logic        SCLK;
    logic        NSYNC;
    logic [7:0]  DIN;

    dac_bank_serializer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .dac_we_i    (dac_we_i),
        .dac_waddr_i (dac_waddr_i),
        .dac_dat_i   (dac_dat_i),
        .dac_raddr_i (dac_raddr_i),
        .dac_dat_o   (dac_dat_o),
        .update_i    (update_i),
        .busy_o      (busy_o),
        .SCLK        (SCLK),
        .NSYNC       (NSYNC),
        .DIN         (DIN)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [15:0] wdat;
        logic [4:0]  raddr;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        int                 len;
        int                 falls;
        logic [7:0][23:0]   fr;
    } win_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          busy_cnt = 0;
    logic [15:0] model [32];
    win_t        wq [$];
    vec_t        tbl [8];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bus decoder: collects DIN on every SCLK falling edge inside an NSYNC-low window
    initial begin : monitor
        int               low_len;
        int               fall_cnt;
        logic             prev_sclk;
        logic             prev_nsync;
        logic [7:0][23:0] cap;
        win_t             w;
        low_len = 0; fall_cnt = 0; prev_sclk = 1'b0; prev_nsync = 1'b1; cap = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                low_len = 0; fall_cnt = 0; prev_sclk = 1'b0; prev_nsync = 1'b1;
            end else begin
                if (busy_o) busy_cnt++;
                if (!NSYNC) begin
                    low_len++;
                    if (prev_sclk && !SCLK) begin
                        fall_cnt++;
                        for (int k = 0; k < 8; k++) cap[k] = {cap[k][22:0], DIN[k]};
                    end
                end else if (!prev_nsync) begin
                    w.len = low_len; w.falls = fall_cnt; w.fr = cap;
                    wq.push_back(w);
                    low_len = 0; fall_cnt = 0;
                end
                prev_sclk  = SCLK;
                prev_nsync = NSYNC;
            end
        end
    end

    task automatic write_reg(input logic [4:0] a, input logic [15:0] d);
        dac_we_i = 1'b1; dac_waddr_i = a; dac_dat_i = d;
        tick();
        dac_we_i = 1'b0;
        model[a] = d;
    endtask

    task automatic read_check(input logic [4:0] a);
        dac_raddr_i = a;
        tick();
        check($sformatf("read[%0d]", a), 32'(dac_dat_o), 32'(model[a]));
    endtask

    task automatic check_idle(input string nm);
        check({nm, ".nsync"}, 32'(NSYNC), 32'd1);
        check({nm, ".sclk"},  32'(SCLK),  32'd0);
        check({nm, ".din"},   32'(DIN),   32'd0);
        check({nm, ".busy"},  32'(busy_o), 32'd0);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy_o && n < max) begin
            tick();
            n++;
        end
        if (busy_o) begin
            n_vec++; n_err++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", max);
        end
    endtask

    task automatic start_update();
        busy_cnt = 0;
        wq.delete();
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
    endtask

    // Expected frames come straight from the setpoint model: window c carries channel c
    task automatic check_windows(input string nm);
        logic [23:0] exp;
        check({nm, ".nwin"}, 32'(wq.size()), 32'd4);
        for (int c = 0; c < 4 && c < wq.size(); c++) begin
            check($sformatf("%s.len%0d", nm, c),   32'(wq[c].len),   32'd48);
            check($sformatf("%s.falls%0d", nm, c), 32'(wq[c].falls), 32'd24);
            for (int k = 0; k < 8; k++) begin
                exp = {4'h3, 2'b00, 2'(c), model[4 * k + c]};
                check($sformatf("%s.frame c%0d k%0d", nm, c, k), 32'(wq[c].fr[k]), 32'(exp));
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; dac_we_i = 1'b0; dac_waddr_i = '0; dac_dat_i = '0;
        dac_raddr_i = '0; update_i = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 16'd0;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check_idle("reset");
        for (int n = 0; n < 32; n++) read_check(5'(n));

        for (int n = 0; n < 32; n++) write_reg(5'(n), 16'h1000 + 16'(n));

        tbl[0] = '{1'b0, 5'd0,  16'h0000, 5'd0,  16'h1000};
        tbl[1] = '{1'b0, 5'd0,  16'h0000, 5'd13, 16'h100D};
        tbl[2] = '{1'b0, 5'd0,  16'h0000, 5'd31, 16'h101F};
        tbl[3] = '{1'b0, 5'd0,  16'h0000, 5'd5,  16'h1005};
        tbl[4] = '{1'b1, 5'd5,  16'hBEEF, 5'd5,  16'h1005};
        tbl[5] = '{1'b0, 5'd0,  16'h0000, 5'd5,  16'hBEEF};
        tbl[6] = '{1'b1, 5'd5,  16'h1005, 5'd5,  16'hBEEF};
        tbl[7] = '{1'b0, 5'd0,  16'h0000, 5'd5,  16'h1005};
        for (int i = 0; i < 8; i++) begin
            dac_we_i = tbl[i].we; dac_waddr_i = tbl[i].waddr;
            dac_dat_i = tbl[i].wdat; dac_raddr_i = tbl[i].raddr;
            tick();
            dac_we_i = 1'b0;
            if (tbl[i].we) model[tbl[i].waddr] = tbl[i].wdat;
            check($sformatf("tbl[%0d]", i), 32'(dac_dat_o), 32'(tbl[i].exp));
        end

        // Full load; extra update pulses at busy cycle 50 and on the final busy cycle
        start_update();
        check("busy_rise", 32'(busy_o), 32'd1);
        for (int n = 1; n <= 204; n++) begin
            update_i = (n == 50) || (n == 204);
            tick();
        end
        update_i = 1'b0;
        check("busy_fall", 32'(busy_o), 32'd0);
        repeat (4) tick();
        check_idle("after_update");
        check("busy_cycles", 32'(busy_cnt), 32'd204);
        check_windows("upd1");
        if (wq.size() > 2) check("din3_c2", 32'(wq[2].fr[3]), 32'h0032100E);

        // Write during frame c=0 to a channel not yet loaded
        start_update();
        repeat (10) tick();
        write_reg(5'd31, 16'hABCD);
        wait_idle(400);
        check("busy_cycles2", 32'(busy_cnt), 32'd204);
        check_windows("late_wr");
        if (wq.size() > 3) check("din7_c3", 32'(wq[3].fr[7][15:0]), 32'hABCD);

        // Randomized setpoints checked against the model
        for (int it = 0; it < 5; it++) begin
            for (int j = 0; j < 10; j++) write_reg(5'($urandom_range(31)), 16'($urandom));
            for (int j = 0; j < 4; j++) read_check(5'($urandom_range(31)));
            start_update();
            wait_idle(400);
            check($sformatf("rnd%0d.busy", it), 32'(busy_cnt), 32'd204);
            check_windows($sformatf("rnd%0d", it));
        end

        // Reset in the middle of shifting
        start_update();
        repeat (20) tick();
        rst_i = 1'b1;
        tick();
        check_idle("mid_reset");
        rst_i = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 16'd0;
        for (int n = 0; n < 32; n++) read_check(5'(n));
        repeat (3) tick();
        check_idle("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dac_bank_serializer.md
Name: dac_bank_serializer

Overview:
- Holds 32 16-bit DAC setpoints in a register file, written and read by the register interface (32-word space, 5-bit addresses).
- On an update request, serially loads all setpoints into 8 external quad-channel DAC chips.
- The 8 chips share SCLK/NSYNC and each has its own data line DIN[k].
- Sits between the PLX/register front end and the board threshold DACs, in the 33 MHz domain.

Parameters:
- NUM_CHIPS, 8, number of DAC chips (width of DIN).
- CH_PER_CHIP, 4, channels per chip; NUM_CHIPS*CH_PER_CHIP must equal 32.
- DAC_CMD, 4'b0011, command nibble placed in every frame (write-and-update channel).

Ports:
- clk_i  in  1  system clock (33 MHz); all logic is on its rising edge.
- rst_i  in  1  synchronous active-high reset.
- dac_we_i  in  1  write strobe for the register file.
- dac_waddr_i  in  5  write address.
- dac_dat_i  in  16  write data.
- dac_raddr_i  in  5  read address.
- dac_dat_o  out  16  read data, registered.
- update_i  in  1  single-cycle request to load all chips.
- busy_o  out  1  high while a load sequence runs.
- SCLK  out  1  shared serial clock, clk_i/2 during shifting.
- NSYNC  out  1  shared active-low frame sync.
- DIN  out  8  serial data, one line per chip, MSB first.

Behaviour:
- Reset (synchronous, active-high):
  - All 32 registers = 0; dac_dat_o = 0; busy_o = 0; SCLK = 0; NSYNC = 1; DIN = 0; FSM = IDLE.
  - Reset mid-sequence aborts immediately with the same values.
- Register file:
  - dac_we_i=1 writes dac_dat_i to reg[dac_waddr_i] at the clock edge. Writes are allowed at any time, including while busy.
  - dac_dat_o <= reg[dac_raddr_i], one-cycle latency.
  - A read and a write to the same address in the same cycle return the old value.
- Mapping: chip k (DIN[k]), channel c uses reg[CH_PER_CHIP*k + c].
- Frame (24 bits, MSB first) = {DAC_CMD[3:0], 2'b00, c[1:0], data[15:0]}.
- FSM states: IDLE, LOAD, SHIFT, GAP.
  - IDLE: busy_o=0, NSYNC=1, SCLK=0. update_i=1 -> LOAD with c=0. busy_o is high from the next cycle.
  - LOAD (1 cycle): snapshot reg[4k+c] for all k into 8 shift registers. NSYNC stays 1.
  - SHIFT (48 cycles): NSYNC=0. For bit i=23..0, two cycles each:
    - first cycle SCLK=1, DIN[k]=frame_k[i];
    - second cycle SCLK=0, DIN unchanged.
    - The DAC samples on the SCLK falling edge.
  - GAP (2 cycles): NSYNC=1, SCLK=0, DIN=0. Then if c<3: c++, -> LOAD. Else -> IDLE, and busy_o drops on the cycle the FSM enters IDLE.
- Totals: 51 cycles per channel; busy_o high for exactly 204 cycles per update.
- Only registers snapshotted at each LOAD are sent. A write during busy to a channel not yet loaded is transmitted; a write to an already-loaded channel waits for the next update.
- update_i while busy_o=1 is ignored, not queued.
- update_i on the same cycle busy_o falls is ignored. A new sequence starts only from an update_i sampled while the FSM is IDLE.
- All outputs are registered; no combinational path from inputs to SCLK/NSYNC/DIN.

Test Plan:
- Reset, then read all 32 addresses -> dac_dat_o=0 each, one cycle after the address. Idle outputs: NSYNC=1, SCLK=0, DIN=0, busy_o=0.
- Write reg[n]=16'h1000+n for n=0..31, read back -> exact values. Same-cycle read/write of addr 5 returns the old value.
- With the values above, pulse update_i:
  - busy_o high 204 cycles, exactly 4 NSYNC-low windows of 48 cycles, 24 SCLK falling edges per window.
  - DIN[3] on frame c=2 decodes to 24'h3_2_100E (cmd 3, addr byte 0x02, data reg[14]=0x100E).
- Pulse update_i again at cycle 50 of busy -> ignored; total busy is still 204 cycles.
- Write reg[31]=16'hABCD during frame c=0 -> frame c=3 on DIN[7] carries data 0xABCD.
- Assert rst_i during SHIFT -> next cycle NSYNC=1, SCLK=0, DIN=0, busy_o=0, all registers read 0.
